// File: rtl/regfile_access_ctrl.sv
// Host/debug access to the 32-entry register file: stalls the core, then reads, writes
// or dumps registers through the write port and RS1 port, returning valid/ready responses.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake (op, addr, wdata)
//   cmd_op_i                        00 read, 01 write, 10 dump all, 11 illegal
//   rsp_valid_o/rsp_ready_i         response handshake (addr, data, last, err)
//   stall_req_o/stall_ack_i         core freeze request / acknowledge
//   rf_wr_en_o/rf_wr_addr_o/rf_wr_data_o   register file write port
//   rf_rd_addr_o/rf_rd_data_i       register file RS1 read port (combinational)
module regfile_access_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  rsp_err_o,
  output logic                  stall_req_o,
  input  logic                  stall_ack_i,
  output logic                  rf_wr_en_o,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_o,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_i
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [15:0] TIMEOUT = 16'(STALL_TIMEOUT);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [15:0] cnt_inc;
  logic        addr_zero;
  logic        is_wr;
  logic        owns_rf;

  assign cnt_inc   = cnt_q + 16'd1;
  assign addr_zero = (addr_q == '0);
  assign is_wr     = (op_q == OP_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          wdata_d = cmd_wdata_i;
          cnt_d   = '0;
          addr_d  = (cmd_op_i == OP_DUMP) ? '0 : cmd_addr_i;
          if (cmd_op_i == OP_ILL) begin
            state_d    = RESP;
            rsp_addr_d = cmd_addr_i;
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (stall_ack_i) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else if (cnt_inc == TIMEOUT) begin
          // Core never froze: error out and release the stall.
          state_d    = RESP;
          cnt_d      = '0;
          rsp_addr_d = addr_q;
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACCESS: begin
        state_d    = RESP;
        rsp_addr_d = addr_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = (op_q != OP_DUMP) || (addr_q == LAST_ADDR);
        if (is_wr) begin
          rsp_data_d = addr_zero ? '0 : wdata_q;
        end else begin
          rsp_data_d = rf_rd_data_i;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (op_q == OP_DUMP && !rsp_err_q &&
              addr_q != LAST_ADDR) begin
            state_d = ACCESS;
            addr_d  = addr_q + ADDR_WIDTH'(1);
          end else begin
            state_d    = IDLE;
            op_d       = OP_RD;
            addr_d     = '0;
            wdata_d    = '0;
            rsp_addr_d = '0;
            rsp_data_d = '0;
            rsp_last_d = 1'b0;
            rsp_err_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error responses (illegal op, timeout) never hold the core.
  assign owns_rf = (state_q == REQ) || (state_q == ACCESS) ||
                   (state_q == RESP && !rsp_err_q);

  assign cmd_ready_o = (state_q == IDLE);
  assign stall_req_o = owns_rf;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_err_o   = rsp_err_q;

  assign rf_wr_en_o   = (state_q == ACCESS) && is_wr && !addr_zero;
  assign rf_wr_addr_o = (owns_rf && is_wr) ? addr_q : '0;
  assign rf_wr_data_o = (owns_rf && is_wr) ? wdata_q : '0;
  assign rf_rd_addr_o = owns_rf ? addr_q : '0;

endmodule
